pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_entry_reg.sv | 50 +++++
 rtl/pipe_skid_stage.sv | 154 +++++++++++++++
 tb/tb_pipe_skid_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types, defaults and lane helper for the skid stage
// Purpose: state encoding, default geometry and the lane bit-offset helper
// used by pipe_skid_stage and pipe_entry_reg.
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_LANES  = 2;

    // Encoding equals the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Lowest bit of lane 'lane' in a packed multi-lane payload.
    function automatic int lane_lsb(input int lane, input int data_w);
        return lane * data_w;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one masked multi-lane entry register
// Purpose: holds one transfer (lane mask + payload). Disabled lanes are
// zeroed on capture. clear_i has priority over load_i.
// Ports:
//   clk, rst          clock, async active-high reset
//   load_i, clear_i   capture the input / zero the entry
//   lane_en_i, data_i transfer to capture
//   lane_en_o, data_o stored transfer
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic                    clear_i,
    input  logic [LANES-1:0]        lane_en_i,
    input  logic [LANES*DATA_W-1:0] data_i,
    output logic [LANES-1:0]        lane_en_o,
    output logic [LANES*DATA_W-1:0] data_o
);

    logic [LANES-1:0]        lane_en_q;
    logic [LANES*DATA_W-1:0] data_q;
    logic [LANES*DATA_W-1:0] masked_data;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign masked_data[lane_lsb(i, DATA_W) +: DATA_W] =
            lane_en_i[i] ? data_i[lane_lsb(i, DATA_W) +: DATA_W] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_en_q <= '0;
            data_q    <= '0;
        end else if (clear_i) begin
            lane_en_q <= '0;
            data_q    <= '0;
        end else if (load_i) begin
            lane_en_q <= lane_en_i;
            data_q    <= masked_data;
        end
    end

    assign lane_en_o = lane_en_q;
    assign data_o    = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry skid buffer with registered in_ready
// Purpose: pipeline stage that breaks the ready path. A main entry drives the
// output; a skid entry absorbs the transfer accepted while the downstream
// stalls, so in_ready comes straight from a flop.
// Ports:
//   clk, rst                       clock, async active-high reset
//   flush                          synchronous discard of all held entries
//   in_valid/in_ready              upstream handshake
//   in_lane_en/in_data             offered transfer (lane i at [i*DATA_W +: DATA_W])
//   out_valid/out_ready            downstream handshake
//   out_lane_en/out_data           main entry (zero when empty)
//   occupancy                      held entries, 0..2
//   stall_cnt                      saturating count of backpressure cycles
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_en,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_en,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        stall_cnt
);

    state_e                  state_q, state_d;
    logic                    in_ready_q;
    logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
    logic                    in_fire, out_fire;
    logic                    main_load, main_clear, main_from_skid;
    logic                    skid_load, skid_clear;
    logic [LANES-1:0]        main_lane_en, skid_lane_en, main_src_lane_en;
    logic [LANES*DATA_W-1:0] main_data, skid_data, main_src_data;

    // An all-lanes-off offer is accepted but carries nothing.
    assign in_fire  = in_valid & in_ready_q & (|in_lane_en);
    assign out_fire = out_valid & out_ready;

    // State register; in_ready is precomputed from the next state so it
    // never depends combinationally on out_ready. It stays low in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    // Next state; flush overrides any handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) state_d = HALF;
                HALF: begin
                    if (in_fire && !out_fire)      state_d = FULL;
                    else if (out_fire && !in_fire) state_d = EMPTY;
                end
                FULL:    if (out_fire) state_d = HALF;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Entry controls and status outputs.
    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        occupancy      = 2'd0;
        case (state_q)
            EMPTY: main_load = in_fire;
            HALF: begin
                occupancy  = 2'd1;
                main_load  = in_fire & out_fire;
                skid_load  = in_fire & ~out_fire;
                main_clear = out_fire & ~in_fire;
            end
            FULL: begin
                occupancy      = 2'd2;
                main_from_skid = 1'b1;
                main_load      = out_fire;
                skid_clear     = out_fire;
            end
            default: occupancy = 2'd0;
        endcase
        if (flush) begin
            main_load  = 1'b0;
            skid_load  = 1'b0;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end
    end

    assign main_src_lane_en = main_from_skid ? skid_lane_en : in_lane_en;
    assign main_src_data    = main_from_skid ? skid_data    : in_data;

    pipe_entry_reg #(.DATA_W(DATA_W), .LANES(LANES)) u_main (
        .clk       (clk),
        .rst       (rst),
        .load_i    (main_load),
        .clear_i   (main_clear),
        .lane_en_i (main_src_lane_en),
        .data_i    (main_src_data),
        .lane_en_o (main_lane_en),
        .data_o    (main_data)
    );

    pipe_entry_reg #(.DATA_W(DATA_W), .LANES(LANES)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load_i    (skid_load),
        .clear_i   (skid_clear),
        .lane_en_i (in_lane_en),
        .data_i    (in_data),
        .lane_en_o (skid_lane_en),
        .data_o    (skid_data)
    );

    // Backpressure counter saturates and ignores flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != EMPTY);
    assign out_lane_en = out_valid ? main_lane_en : '0;
    assign out_data    = out_valid ? main_data : '0;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - scoreboard bench for pipe_skid_stage
module tb_pipe_skid_stage;

    localparam int DATA_W = 32;
    localparam int LANES  = 2;
    localparam int CNT_W  = 16;
    localparam int PW     = LANES * DATA_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] in_lane_en;
    logic [PW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [LANES-1:0] out_lane_en;
    logic [PW-1:0]    out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    logic [LANES+PW-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_lane_en  (in_lane_en),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_lane_en (out_lane_en),
        .out_data    (out_data),
        .occupancy   (occupancy),
        .stall_cnt   (stall_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a transfer that the bench knows will be accepted, and queue the
    // hand-computed masked result.
    task automatic send(input logic [1:0] lanes, input logic [63:0] data,
                        input logic [1:0] exp_lanes, input logic [63:0] exp_data);
        in_valid   = 1'b1;
        in_lane_en = lanes;
        in_data    = data;
        exp_q.push_back({exp_lanes, exp_data});
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_lane_en = '0;
        in_data    = '0;
    endtask

    // Monitor: every output handshake pops one expected transfer.
    initial begin : monitor
        logic [LANES+PW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && !flush && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got data %0h, expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_lane_en", 64'(out_lane_en), 64'(e[LANES+PW-1:PW]));
                    check("sb_data", out_data, e[PW-1:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        idle();
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("release_in_ready", 64'(in_ready), 64'd1);

        // Single transfer, one cycle of latency
        send(2'b11, 64'h00000002_00000001, 2'b11, 64'h00000002_00000001);
        step(); idle();
        @(negedge clk);
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("lat_occupancy", 64'(occupancy), 64'd1);
        check("lat_out_data", out_data, 64'h00000002_00000001);
        step();

        // Two transfers under backpressure fill the skid entry
        out_ready = 1'b0;
        send(2'b11, 64'hAAAA_0001_AAAA_0000, 2'b11, 64'hAAAA_0001_AAAA_0000);
        step();
        send(2'b11, 64'hBBBB_0001_BBBB_0000, 2'b11, 64'hBBBB_0001_BBBB_0000);
        step(); idle();
        out_ready = 1'b1;
        @(negedge clk);
        check("full_occupancy", 64'(occupancy), 64'd2);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_stall_cnt", 64'(stall_cnt), 64'd1);
        step();
        @(negedge clk);
        check("drain_occupancy", 64'(occupancy), 64'd1);
        step();
        @(negedge clk);
        check("drained_occupancy", 64'(occupancy), 64'd0);
        check("drained_stall_cnt", 64'(stall_cnt), 64'd1);

        // Simultaneous accept and emit in HALF
        send(2'b11, 64'hEEEE_0001_EEEE_0000, 2'b11, 64'hEEEE_0001_EEEE_0000);
        step();
        send(2'b10, 64'hFFFF_0001_FFFF_0000, 2'b10, 64'hFFFF_0001_0000_0000);
        step(); idle();
        @(negedge clk);
        check("pass_occupancy", 64'(occupancy), 64'd1);
        step();

        // Masked lane is zeroed on capture
        send(2'b01, 64'h0000DEAD_00000005, 2'b01, 64'h00000000_00000005);
        step(); idle();
        @(negedge clk);
        check("mask_lane_en", 64'(out_lane_en), 64'd1);
        check("mask_data", out_data, 64'h00000000_00000005);
        step();

        // Flush from FULL overrides the output handshake
        out_ready = 1'b0;
        send(2'b11, 64'hC0C0_0001_C0C0_0000, 2'b11, 64'hC0C0_0001_C0C0_0000);
        step();
        send(2'b11, 64'hD0D0_0001_D0D0_0000, 2'b11, 64'hD0D0_0001_D0D0_0000);
        step(); idle();
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("flush_in_ready_pre", 64'(in_ready), 64'd0);
        check("flush_occupancy_pre", 64'(occupancy), 64'd2);
        exp_q.delete();
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flush_occupancy", 64'(occupancy), 64'd0);
        check("flush_out_data", out_data, 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_stall_cnt", 64'(stall_cnt), 64'd2);

        // All-lanes-off offer is swallowed
        in_valid = 1'b1; in_lane_en = 2'b00; in_data = 64'h1234_5678_9ABC_DEF0;
        step(); idle();
        @(negedge clk);
        check("nop_occupancy", 64'(occupancy), 64'd0);
        check("nop_out_valid", 64'(out_valid), 64'd0);
        check("nop_in_ready", 64'(in_ready), 64'd1);

        // Long stall saturates the counter, then reset mid-cycle
        out_ready = 1'b0;
        send(2'b11, 64'h00000077_00000066, 2'b11, 64'h00000077_00000066);
        step(); idle();
        repeat (70000) step();
        @(negedge clk);
        check("sat_stall_cnt", 64'(stall_cnt), 64'hFFFF);
        check("sat_occupancy", 64'(occupancy), 64'd1);
        check("sat_out_data", out_data, 64'h00000077_00000066);
        #2;
        rst = 1'b1;
        #1;
        check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_occupancy", 64'(occupancy), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        check("arst_out_data", out_data, 64'd0);
        exp_q.delete();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("rearm_in_ready", 64'(in_ready), 64'd1);
        check("rearm_out_valid", 64'(out_valid), 64'd0);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
